// File: rtl/minefield_if.sv
// minefield_if: start/safe-tile request and generated board returned to the render path
interface minefield_if;
  logic         start;
  logic [5:0]   safe_index;
  logic         busy;
  logic         done;
  logic [63:0]  mine_map;
  logic [255:0] adj;
  modport master(output start, safe_index, input busy, done, mine_map, adj);
  modport slave(input start, safe_index, output busy, done, mine_map, adj);
endinterface

// File: rtl/minefield_gen.sv
// minefield_gen: LFSR mine placement avoiding one safe tile, then per-tile neighbour counts
module minefield_gen #(
  parameter int          GRID_SIZE = 8,
  parameter int          NUM_MINES = 10,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input logic       clk,
  input logic       rst,
  minefield_if.slave mf
);
  typedef enum logic [2:0] {IDLE, CLEAR, PLACE, COUNT, DONE} state_t;
  state_t         state_q, state_d;
  logic [15:0]    lfsr_q, lfsr_d;
  logic           start_prev_q, start_edge;
  logic [5:0]     safe_q, safe_d, mine_cnt_q, mine_cnt_d, tile_cnt_q, tile_cnt_d, cand;
  logic           busy_q, busy_d, done_q, done_d;
  logic [63:0]    map_q, map_d;
  logic [255:0]   adj_q, adj_d;
  function automatic logic [3:0] nbr_cnt(input logic [63:0] m, input logic [5:0] idx);
    logic [3:0] n;
    int nx, ny;
    n = '0;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++) begin
        nx = int'(idx[2:0]) + dx;
        ny = int'(idx[5:3]) + dy;
        if ((dx != 0 || dy != 0) && nx >= 0 && nx < GRID_SIZE && ny >= 0 && ny < GRID_SIZE)
          n = n + {3'b0, m[6'(ny * GRID_SIZE + nx)]};
      end
    return n;
  endfunction
  assign start_edge = mf.start & ~start_prev_q;
  assign cand       = lfsr_q[5:0];
  assign lfsr_d     = lfsr_q[0] ? ({1'b0, lfsr_q[15:1]} ^ 16'hB400) : {1'b0, lfsr_q[15:1]};
  assign mf.busy     = busy_q;
  assign mf.done     = done_q;
  assign mf.mine_map = map_q;
  assign mf.adj      = adj_q;
  // state and board registers; the LFSR free-runs in every state so user timing adds entropy
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q      <= IDLE;
      lfsr_q       <= LFSR_SEED;
      start_prev_q <= 1'b0;
      safe_q       <= '0;
      mine_cnt_q   <= '0;
      tile_cnt_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      map_q        <= '0;
      adj_q        <= '0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      start_prev_q <= mf.start;
      safe_q       <= safe_d;
      mine_cnt_q   <= mine_cnt_d;
      tile_cnt_q   <= tile_cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      map_q        <= map_d;
      adj_q        <= adj_d;
    end
  // next-state: start edges only honoured when no generation is in flight
  always_comb begin
    state_d    = state_q;
    safe_d     = safe_q;
    mine_cnt_d = mine_cnt_q;
    tile_cnt_d = tile_cnt_q;
    busy_d     = busy_q;
    done_d     = done_q;
    map_d      = map_q;
    adj_d      = adj_q;
    case (state_q)
      IDLE, DONE: if (start_edge) begin
        state_d = CLEAR;
        safe_d  = mf.safe_index;
        done_d  = 1'b0;
      end
      CLEAR: begin
        map_d      = '0;
        adj_d      = '0;
        mine_cnt_d = '0;
        tile_cnt_d = '0;
        busy_d     = 1'b1;
        done_d     = 1'b0;
        state_d    = (NUM_MINES == 0) ? COUNT : PLACE;
      end
      PLACE: begin
        if (!map_q[cand] && cand != safe_q) begin
          map_d[cand] = 1'b1;
          mine_cnt_d  = mine_cnt_q + 6'd1;
        end
        if (mine_cnt_d == 6'(NUM_MINES)) begin
          state_d    = COUNT;
          tile_cnt_d = '0;
        end
      end
      COUNT: begin
        adj_d[{tile_cnt_q, 2'b00} +: 4] = nbr_cnt(map_q, tile_cnt_q);
        tile_cnt_d = tile_cnt_q + 6'd1;
        if (tile_cnt_q == 6'd63) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_minefield_gen.sv
// tb_minefield_gen: scoreboard bench for minefield_gen (10-mine and 0-mine builds)
module tb_minefield_gen;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  typedef struct {int safe; int min_lat; int max_lat; int mines;} exp_t;
  exp_t sbq[$];
  minefield_if m10();
  minefield_if m0();
  minefield_gen #(.NUM_MINES(10)) u10 (.clk(clk), .rst(rst), .mf(m10));
  minefield_gen #(.NUM_MINES(0))  u0  (.clk(clk), .rst(rst), .mf(m0));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic int ref_nbr(input logic [63:0] m, input int i);
    int n, xi, yi, xj, yj;
    n = 0;
    xi = i % 8;
    yi = i / 8;
    for (int j = 0; j < 64; j++) begin
      xj = j % 8;
      yj = j / 8;
      if (j != i && m[j] && xi - xj <= 1 && xj - xi <= 1 && yi - yj <= 1 && yj - yi <= 1) n++;
    end
    return n;
  endfunction
  task automatic check_board(input logic [63:0] map, input logic [255:0] adj, input exp_t e, input int lat);
    int cmax, emax, x, y, v;
    bit xe, ye;
    cmax = 0;
    emax = 0;
    chk("popcount", $countones(map), e.mines);
    chk("safe_bit", map[e.safe], 0);
    chk("lat_min", lat >= e.min_lat, 1);
    chk("lat_max", lat <= e.max_lat, 1);
    for (int i = 0; i < 64; i++) begin
      v = int'(adj[i*4 +: 4]);
      chk($sformatf("adj%0d", i), v, ref_nbr(map, i));
      x = i % 8;
      y = i / 8;
      xe = (x == 0 || x == 7);
      ye = (y == 0 || y == 7);
      if (xe && ye) cmax = (v > cmax) ? v : cmax;
      else if (xe || ye) emax = (v > emax) ? v : emax;
    end
    chk("corner_le3", cmax <= 3, 1);
    chk("edge_le5", emax <= 5, 1);
  endtask
  task automatic gen10(input int safe, input bit hold, input bit repulse);
    exp_t e;
    int t0, pop_prev, viol;
    bit was_done;
    logic [63:0] map_s;
    was_done = m10.done;
    e = '{safe, 76, 2000, 10};
    sbq.push_back(e);
    @(negedge clk);
    m10.safe_index = 6'(safe);
    m10.start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    if (was_done) chk("done_fall", m10.done, 0);
    if (!hold) m10.start = 1'b0;
    @(negedge clk);
    chk("busy_rise", m10.busy, 1);
    pop_prev = 0;
    viol = 0;
    while (!m10.done && cyc - t0 < 2000) begin
      if (repulse && cyc - t0 == 20) m10.start = 1'b1;
      if (repulse && cyc - t0 == 21) m10.start = 1'b0;
      if ($countones(m10.mine_map) < pop_prev) viol++;
      pop_prev = $countones(m10.mine_map);
      if (!m10.busy) viol++;
      @(negedge clk);
    end
    chk("no_restart", viol, 0);
    chk("done", m10.done, 1);
    e = sbq.pop_front();
    check_board(m10.mine_map, m10.adj, e, cyc - t0);
    if (hold) begin
      map_s = m10.mine_map;
      repeat (5) @(negedge clk);
      chk("hold_done", m10.done, 1);
      chk("hold_frozen", m10.mine_map, map_s);
      m10.start = 1'b0;
    end
  endtask
  initial begin
    exp_t e;
    int k, t0;
    m10.start = 1'b0;
    m10.safe_index = '0;
    m0.start = 1'b0;
    m0.safe_index = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", m10.busy, 0);
    chk("rst_done", m10.done, 0);
    chk("rst_map", m10.mine_map, 0);
    chk("rst_adj", |m10.adj, 0);
    chk("rst0_done", m0.done, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    gen10(0, 1'b0, 1'b0);
    gen10(27, 1'b0, 1'b1);
    gen10(5, 1'b1, 1'b0);
    @(negedge clk);
    m10.safe_index = 6'd9;
    m10.start = 1'b1;
    @(negedge clk);
    m10.start = 1'b0;
    @(negedge clk);
    k = 0;
    while ($countones(m10.mine_map) != 10 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("place_before_rst", $countones(m10.mine_map), 10);
    repeat (30) @(negedge clk);
    chk("busy_mid_count", m10.busy, 1);
    #1 rst = 1'b0;
    #1;
    chk("abort_busy", m10.busy, 0);
    chk("abort_done", m10.done, 0);
    chk("abort_map", m10.mine_map, 0);
    chk("abort_adj", |m10.adj, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("no_partial_done", m10.done, 0);
    gen10(27, 1'b0, 1'b0);
    e = '{3, 66, 66, 0};
    sbq.push_back(e);
    @(negedge clk);
    m0.safe_index = 6'd3;
    m0.start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    m0.start = 1'b0;
    while (!m0.done && cyc - t0 < 2000) @(negedge clk);
    chk("done0", m0.done, 1);
    e = sbq.pop_front();
    check_board(m0.mine_map, m0.adj, e, cyc - t0);
    chk("adj0_all", |m0.adj, 0);
    chk("sb_empty", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
